medac_phase_sched: RTL and testbench
====================================

Name: medac_phase_sched

Overview:
- Windowed phase-selection scheduler for the MEDAC clock-phase mux.
- Accumulates lagging/origin/leading error pulses over a fixed observation window and decides whether to step the sampling phase.
- Drives the phase mux through a request/acknowledge handshake so the glitch-free mux controls when the switch happens.
- Applies a post-switch hold-off and reports lock status to the system controller.

Parameters:
- WIN_LEN, 64, observation window length in clk cycles (≥4).
- THRESH, 4, minimum error count in a window before a phase step is considered (≥1, ≤CNT_MAX).
- CNT_W, 6, error counter width; counters saturate at CNT_MAX = 2^CNT_W-1.
- HOLD_CYC, 16, cycles after a switch during which errors are ignored.
- ACK_TO, 32, cycles to wait for mux_ack before aborting a switch.
- LOCK_WIN, 4, consecutive no-change windows required to assert locked.

Ports:
- clk  in  1  block clock, posedge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run scheduler; low returns to IDLE (see Behaviour).
- error_lagging  in  1  per-cycle lagging-error pulse.
- error_origin  in  1  per-cycle origin-error pulse.
- error_leading  in  1  per-cycle leading-error pulse.
- mux_ack  in  1  phase mux reports the requested select is applied.
- clk_sel  out  2  phase select: 00 leading, 01 origin, 10 lagging; 11 never driven.
- sel_req  out  1  switch request, held high until ack or timeout.
- locked  out  1  stable-phase indicator.
- sw_fail  out  1  sticky switch-timeout flag.
- win_errs  out  CNT_W  total error count of the last completed window (saturating).

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE, clk_sel=01, sel_req=0, locked=0, sw_fail=0, win_errs=0.
  - All counters are cleared.
- Phase index mapping: leading=0, origin=1, lagging=2. clk_sel is the registered index; it changes only on ack or abort.
- IDLE:
  - Counters are cleared.
  - enable=1 → OBSERVE on the next edge, with the window counter at 0.
- OBSERVE:
  - One counter each for lag, orig and lead. Each increments when its error input is 1 in that cycle; all three may increment in the same cycle. Each saturates at CNT_MAX.
  - After exactly WIN_LEN OBSERVE cycles → DECIDE.
- DECIDE (1 cycle):
  - win_errs is set to the saturating sum of lag, orig and lead.
  - If lag ≥ THRESH and lag > lead: target = index-1, floored at 0.
  - Else if lead ≥ THRESH and lead > lag: target = index+1, capped at 2.
  - Else (including a lag==lead tie, or only origin errors): target = index.
  - If target == index: increment the stable counter, which saturates at LOCK_WIN. Counters clear → OBSERVE.
  - If target != index: the stable counter clears, locked drops in the same cycle, and the block goes to SWITCH with target latched.
- SWITCH:
  - sel_req=1 while in this state. The target is presented on the internal sel_nxt; clk_sel keeps the old value.
  - If mux_ack=1: clk_sel<=target, sel_req<=0 → HOLD.
  - Otherwise, after ACK_TO cycles without ack: sel_req<=0, sw_fail<=1, clk_sel unchanged → HOLD.
  - mux_ack outside SWITCH is ignored.
- HOLD:
  - Error inputs are ignored.
  - After HOLD_CYC cycles, counters clear → OBSERVE.
- locked = 1 when the stable counter equals LOCK_WIN. It is registered and updates in the DECIDE cycle.
- enable=0:
  - From OBSERVE, DECIDE or HOLD → IDLE next edge. clk_sel and sw_fail are retained; locked clears.
  - In SWITCH, the handshake completes (ack or timeout) first, then the block goes to IDLE.
- sw_fail clears only on reset or on an IDLE→OBSERVE transition.
- Reset mid-SWITCH: sel_req drops immediately (async) and clk_sel returns to 01.

Decomposition:
- Shared package medac_pkg holds:
  - Phase encodings: PH_LEAD=2'b00, PH_ORIG=2'b01, PH_LAG=2'b10.
  - State encodings: IDLE, OBSERVE, DECIDE, SWITCH, HOLD.
  - A clog2 function for counter widths.
- One sub-module, medac_err_acc: three saturating counters plus a saturating-sum output, with clear and count-enable inputs.
- The FSM, window, hold and timeout counters stay in the top module.

Test Plan:
- Reset/idle: rst_n=0 then 1, enable=0 for 100 cycles → clk_sel=01, sel_req=0, locked=0, sw_fail=0, win_errs=0 throughout.
- Lagging step: enable=1, 5 error_lagging pulses in a window (defaults) → DECIDE sets win_errs=5, sel_req rises. mux_ack after 3 cycles → clk_sel=00 the cycle after ack, sel_req=0, errors ignored for 16 cycles.
- Boundary/tie: from clk_sel=00, 10 lag errors → no request and clk_sel stays 00. Next window, lag=5 and lead=5 → no switch. 4 consecutive quiet windows → locked=1 at the 4th DECIDE.
- Saturation/simultaneous: all three error inputs high for the whole 64-cycle window → each counter 63, win_errs=63. lag==lead → no switch.
- Timeout: lead=6 in a window, mux_ack held 0 → sel_req high for exactly 32 cycles, then sw_fail=1, clk_sel unchanged, HOLD entered. sw_fail persists until enable is toggled 0→1.
- Mid-operation: enable=0 during SWITCH → request completes on ack, then IDLE. Async rst_n low during SWITCH → sel_req=0 and clk_sel=01 with no clock edge.

Source files
------------

// File: rtl/medac_pkg.sv
// Shared encodings and helpers for the MEDAC phase-selection scheduler.
package medac_pkg;

    localparam logic [1:0] PH_LEAD = 2'b00;
    localparam logic [1:0] PH_ORIG = 2'b01;
    localparam logic [1:0] PH_LAG  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        OBSERVE,
        DECIDE,
        SWITCH,
        HOLD
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/medac_err_acc.sv
// Three saturating error counters (bit i of err is phase index i: lead, orig, lag)
// plus the saturating sum of all three.
module medac_err_acc #(
    parameter int CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [2:0]            err,
    output logic [2:0][CNT_W-1:0] cnt,
    output logic [CNT_W-1:0]      sum_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W+1:0] sum_full;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (clr) begin
                    cnt_reg <= '0;
                end else if (en && err[gi] && (cnt_reg != CNT_MAX)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign cnt[gi] = cnt_reg;
        end
    endgenerate

    // Two extra bits hold the full three-way sum before clamping.
    assign sum_full = {2'b00, cnt[0]} + {2'b00, cnt[1]} + {2'b00, cnt[2]};
    assign sum_sat  = (sum_full > {2'b00, CNT_MAX}) ? CNT_MAX : sum_full[CNT_W-1:0];

endmodule

// File: rtl/medac_phase_sched.sv
// Windowed phase-selection scheduler: counts phase errors per window, steps the
// mux select via a req/ack handshake, then holds off and tracks lock.
module medac_phase_sched
    import medac_pkg::*;
#(
    parameter int WIN_LEN  = 64,
    parameter int THRESH   = 4,
    parameter int CNT_W    = 6,
    parameter int HOLD_CYC = 16,
    parameter int ACK_TO   = 32,
    parameter int LOCK_WIN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             error_lagging,
    input  logic             error_origin,
    input  logic             error_leading,
    input  logic             mux_ack,
    output logic [1:0]       clk_sel,
    output logic             sel_req,
    output logic             locked,
    output logic             sw_fail,
    output logic [CNT_W-1:0] win_errs
);

    localparam int TMR_MAX = (WIN_LEN > HOLD_CYC) ? ((WIN_LEN > ACK_TO) ? WIN_LEN : ACK_TO)
                                                  : ((HOLD_CYC > ACK_TO) ? HOLD_CYC : ACK_TO);
    localparam int TMR_W   = clog2(TMR_MAX + 1);
    localparam int STB_W   = clog2(LOCK_WIN + 1);

    state_t             state_reg, state_next;
    logic [TMR_W-1:0]   tmr_reg, tmr_next;
    logic [STB_W-1:0]   stable_reg, stable_next;
    logic [1:0]         target_reg, target_next;
    logic [1:0]         clk_sel_reg, clk_sel_next;
    logic               sel_req_reg, sel_req_next;
    logic               locked_reg, locked_next;
    logic               sw_fail_reg, sw_fail_next;
    logic [CNT_W-1:0]   win_errs_reg, win_errs_next;

    logic [2:0][CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0]      acc_sum;
    logic [1:0]            dec_target;
    logic [1:0]            sel_nxt;

    medac_err_acc #(.CNT_W(CNT_W)) u_err_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_reg != OBSERVE),
        .en      (state_reg == OBSERVE),
        .err     ({error_lagging, error_origin, error_leading}),
        .cnt     (acc_cnt),
        .sum_sat (acc_sum)
    );

    assign sel_nxt = target_reg;

    // Step toward the dominant error side; ties and origin-only windows stay put.
    always_comb begin
        dec_target = clk_sel_reg;
        if ((acc_cnt[2] >= CNT_W'(THRESH)) && (acc_cnt[2] > acc_cnt[0])) begin
            dec_target = (clk_sel_reg == PH_LEAD) ? PH_LEAD : clk_sel_reg - 2'd1;
        end else if ((acc_cnt[0] >= CNT_W'(THRESH)) && (acc_cnt[0] > acc_cnt[2])) begin
            dec_target = (clk_sel_reg == PH_LAG) ? PH_LAG : clk_sel_reg + 2'd1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        tmr_next      = tmr_reg + 1'b1;
        stable_next   = stable_reg;
        target_next   = target_reg;
        clk_sel_next  = clk_sel_reg;
        sel_req_next  = sel_req_reg;
        locked_next   = locked_reg;
        sw_fail_next  = sw_fail_reg;
        win_errs_next = win_errs_reg;

        case (state_reg)
            IDLE: begin
                tmr_next    = '0;
                stable_next = '0;
                locked_next = 1'b0;
                if (enable) begin
                    state_next   = OBSERVE;
                    sw_fail_next = 1'b0;
                end
            end
            OBSERVE: begin
                if (!enable) begin
                    state_next  = IDLE;
                    locked_next = 1'b0;
                end else if (tmr_reg == TMR_W'(WIN_LEN - 1)) begin
                    state_next = DECIDE;
                    tmr_next   = '0;
                end
            end
            DECIDE: begin
                win_errs_next = acc_sum;
                tmr_next      = '0;
                if (!enable) begin
                    state_next  = IDLE;
                    locked_next = 1'b0;
                end else if (dec_target == clk_sel_reg) begin
                    state_next  = OBSERVE;
                    stable_next = (stable_reg == STB_W'(LOCK_WIN)) ? stable_reg : stable_reg + 1'b1;
                    locked_next = (stable_reg >= STB_W'(LOCK_WIN - 1));
                end else begin
                    state_next   = SWITCH;
                    stable_next  = '0;
                    locked_next  = 1'b0;
                    target_next  = dec_target;
                    sel_req_next = 1'b1;
                end
            end
            SWITCH: begin
                // The handshake always completes before honouring enable=0.
                if (mux_ack) begin
                    clk_sel_next = sel_nxt;
                    sel_req_next = 1'b0;
                    tmr_next     = '0;
                    state_next   = enable ? HOLD : IDLE;
                end else if (tmr_reg == TMR_W'(ACK_TO - 1)) begin
                    sel_req_next = 1'b0;
                    sw_fail_next = 1'b1;
                    tmr_next     = '0;
                    state_next   = enable ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (!enable) begin
                    state_next  = IDLE;
                    locked_next = 1'b0;
                end else if (tmr_reg == TMR_W'(HOLD_CYC - 1)) begin
                    state_next = OBSERVE;
                    tmr_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            tmr_reg      <= '0;
            stable_reg   <= '0;
            target_reg   <= PH_ORIG;
            clk_sel_reg  <= PH_ORIG;
            sel_req_reg  <= 1'b0;
            locked_reg   <= 1'b0;
            sw_fail_reg  <= 1'b0;
            win_errs_reg <= '0;
        end else begin
            state_reg    <= state_next;
            tmr_reg      <= tmr_next;
            stable_reg   <= stable_next;
            target_reg   <= target_next;
            clk_sel_reg  <= clk_sel_next;
            sel_req_reg  <= sel_req_next;
            locked_reg   <= locked_next;
            sw_fail_reg  <= sw_fail_next;
            win_errs_reg <= win_errs_next;
        end
    end

    assign clk_sel  = clk_sel_reg;
    assign sel_req  = sel_req_reg;
    assign locked   = locked_reg;
    assign sw_fail  = sw_fail_reg;
    assign win_errs = win_errs_reg;

endmodule

// File: tb/tb_medac_phase_sched.sv
// Directed bench for medac_phase_sched at default parameters (64-cycle window,
// threshold 4, 16-cycle hold, 32-cycle ack timeout, lock after 4 windows).
module tb_medac_phase_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       error_lagging;
    logic       error_origin;
    logic       error_leading;
    logic       mux_ack;
    logic [1:0] clk_sel;
    logic       sel_req;
    logic       locked;
    logic       sw_fail;
    logic [5:0] win_errs;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    medac_phase_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .error_lagging (error_lagging),
        .error_origin  (error_origin),
        .error_leading (error_leading),
        .mux_ack       (mux_ack),
        .clk_sel       (clk_sel),
        .sel_req       (sel_req),
        .locked        (locked),
        .sw_fail       (sw_fail),
        .win_errs      (win_errs)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in OBSERVE cycle 0; drives a window, crosses DECIDE, checks outputs.
    task automatic run_window(input string tag, input int nl, input int no, input int nd,
                              input int exp_errs, input int exp_req, input int exp_sel,
                              input int exp_lock);
        for (int i = 0; i < 64; i++) begin
            error_lagging = (i < nl);
            error_origin  = (i < no);
            error_leading = (i < nd);
            tick();
        end
        error_lagging = 1'b0;
        error_origin  = 1'b0;
        error_leading = 1'b0;
        tick();
        $display("window %s lag=%0d orig=%0d lead=%0d -> win_errs=%0d sel_req=%0d clk_sel=%0d locked=%0d",
                 tag, nl, no, nd, win_errs, sel_req, clk_sel, locked);
        check_val({tag, ".win_errs"}, win_errs, exp_errs);
        check_val({tag, ".sel_req"},  sel_req,  exp_req);
        check_val({tag, ".clk_sel"},  clk_sel,  exp_sel);
        check_val({tag, ".locked"},   locked,   exp_lock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi;
        rst_n = 1'b1;
        enable = 1'b0;
        error_lagging = 1'b0;
        error_origin  = 1'b0;
        error_leading = 1'b0;
        mux_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_val("rst.outs", {clk_sel, sel_req, locked, sw_fail, win_errs}, {2'b01, 3'b000, 6'd0});
        repeat (3) tick();
        rst_n = 1'b1;

        for (int c = 0; c < 100; c++) begin
            tick();
            check_val("idle.outs", {clk_sel, sel_req, locked, sw_fail, win_errs}, {2'b01, 3'b000, 6'd0});
        end
        $display("idle phase: 100 cycles observed");

        // Lagging step 01 -> 00 with ack on the third request cycle
        enable = 1'b1;
        tick();
        run_window("lag_step", 5, 0, 0, 5, 1, 1, 0);
        tick();
        tick();
        mux_ack = 1'b1;
        tick();
        mux_ack = 1'b0;
        $display("ack: clk_sel=%0d sel_req=%0d", clk_sel, sel_req);
        check_val("ack.clk_sel", clk_sel, 0);
        check_val("ack.sel_req", sel_req, 0);
        error_leading = 1'b1;
        repeat (16) tick();
        error_leading = 1'b0;
        run_window("hold_ign", 0, 0, 0, 0, 0, 0, 0);

        // Floor at leading, then a lag/lead tie
        run_window("floor", 10, 0, 0, 10, 0, 0, 0);
        run_window("tie", 5, 0, 5, 10, 0, 0, 0);

        enable = 1'b0;
        tick();
        $display("disable: clk_sel=%0d locked=%0d", clk_sel, locked);
        check_val("dis.locked", locked, 0);
        check_val("dis.clk_sel", clk_sel, 0);
        enable = 1'b1;
        tick();

        // Four no-change windows from a cleared stable count
        run_window("lock1", 0, 20, 0, 20, 0, 0, 0);
        run_window("lock2", 0, 0, 0, 0, 0, 0, 0);
        run_window("lock3", 0, 0, 3, 3, 0, 0, 0);
        run_window("lock4", 0, 0, 0, 0, 0, 0, 1);

        // Saturation
        run_window("sat_lag", 64, 0, 0, 63, 0, 0, 1);
        run_window("sat_all", 64, 64, 64, 63, 0, 0, 1);

        // Ack timeout
        run_window("timeout", 0, 0, 6, 6, 1, 0, 0);
        hi = 0;
        while (sel_req === 1'b1 && hi < 40) begin
            hi++;
            tick();
        end
        $display("timeout: sel_req high %0d cycles, sw_fail=%0d clk_sel=%0d", hi, sw_fail, clk_sel);
        check_val("to.req_len", hi, 32);
        check_val("to.sw_fail", sw_fail, 1);
        check_val("to.clk_sel", clk_sel, 0);
        repeat (16) tick();
        run_window("post_to", 0, 0, 0, 0, 0, 0, 0);
        check_val("post_to.sw_fail", sw_fail, 1);
        enable = 1'b0;
        tick();
        check_val("idle.sw_fail", sw_fail, 1);
        enable = 1'b1;
        tick();
        $display("re-enable: sw_fail=%0d", sw_fail);
        check_val("reen.sw_fail", sw_fail, 0);

        // Disable during SWITCH: handshake completes, then IDLE
        run_window("dis_sw", 0, 0, 6, 6, 1, 0, 0);
        enable = 1'b0;
        tick();
        tick();
        check_val("dis_sw.held", sel_req, 1);
        mux_ack = 1'b1;
        tick();
        mux_ack = 1'b0;
        $display("disabled ack: clk_sel=%0d sel_req=%0d", clk_sel, sel_req);
        check_val("dis_sw.clk_sel", clk_sel, 1);
        check_val("dis_sw.sel_req", sel_req, 0);
        enable = 1'b1;
        tick();
        run_window("after_idle", 5, 0, 0, 5, 1, 1, 0);

        // Async reset mid-SWITCH, no clock edge in between
        #2 rst_n = 1'b0;
        #1;
        $display("async reset: clk_sel=%0d sel_req=%0d", clk_sel, sel_req);
        check_val("arst.sel_req", sel_req, 0);
        check_val("arst.clk_sel", clk_sel, 1);
        check_val("arst.win_errs", win_errs, 0);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
